result_serializer: RTL and testbench

Output-side counterpart of the byte-wide operand input buffer in the array multiplier. It captures the complete result matrix from the multiplier core in one cycle. It then streams the matrix out one byte per accepted transfer over a valid/ready byte interface, and pulses `done` after the final byte. It sits between the multiplier datapath and the chip output pins or the host-facing mux.

---
 rtl/result_serializer.sv | 118 +++++++++++
 tb/tb_result_serializer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/result_serializer.sv
// -----------------------------------------------------------------------------
// result_serializer
//
// Captures the full result matrix from the multiplier core in a single cycle.
// It then streams the matrix out one byte per accepted transfer and pulses
// `done` once the final byte has been taken.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   result_in   in   flat result bus; word i = result_in[i*24 +: 24]
//   load        in   capture result_in and start a transfer (only when ready=1)
//   ready       out  idle, a load will be accepted
//   data_out    out  current output byte (8'h00 whenever data_valid=0)
//   data_valid  out  data_out holds a valid byte
//   data_ready  in   consumer accepts the byte this cycle
//   done        out  one-cycle pulse in the cycle after the last byte transfers
//
// Handshake: a byte moves on every rising edge where data_valid && data_ready
// are both high. The producer holds data_valid high and data_out stable until
// that edge, and it never withdraws data_valid once raised. The consumer may
// drive data_ready freely, and it has no combinational effect on any output.
//
// Stream byte k is result_in[8k +: 8] at capture. This makes word 0 go first,
// and within each word the least-significant byte goes first.
// -----------------------------------------------------------------------------
module result_serializer #(
  parameter int NUM_WORDS      = 9,
  parameter int BYTES_PER_WORD = 3
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_WORDS*BYTES_PER_WORD*8-1:0]    result_in,
  input  logic                                     load,
  output logic                                     ready,
  output logic [7:0]                               data_out,
  output logic                                     data_valid,
  input  logic                                     data_ready,
  output logic                                     done
);

  localparam int TOTAL_BYTES = NUM_WORDS * BYTES_PER_WORD;
  localparam int TOTAL_BITS  = TOTAL_BYTES * 8;
  localparam int CNT_W       = $clog2(TOTAL_BYTES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TOTAL_BYTES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [TOTAL_BITS-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]        cnt_q,   cnt_d;
  logic                    done_q,  done_d;

  logic                    xfer;

  // A byte leaves only when both sides agree in SEND.
  assign xfer = (state_q == SEND) && data_ready;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A load in the done cycle is accepted, because the FSM is already back in IDLE.
        if (load) begin
          shreg_d = result_in;
          cnt_d   = '0;
          state_d = SEND;
        end
      end

      SEND: begin
        // load is deliberately not looked at here, so the stream cannot be disturbed.
        if (xfer) begin
          // Zero fill leaves the register all-zero after the last byte.
          // data_out then reads 8'h00 whenever the serializer is idle.
          shreg_d = {8'h00, shreg_q[TOTAL_BITS-1:8]};
          if (cnt_q == LAST_CNT) begin
            // The counter holds at its last value rather than wrapping.
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // All outputs come from flops or from decoding the state register.
  assign ready      = (state_q == IDLE);
  assign data_valid = (state_q == SEND);
  assign data_out   = shreg_q[7:0];
  assign done       = done_q;

endmodule

// File: tb/tb_result_serializer.sv
// -----------------------------------------------------------------------------
// tb_result_serializer
//
// Randomized and directed bench for result_serializer.
// The reference model keeps the expected bytes of the active transfer in a
// queue. The model decides ready/data_valid/done from whether that queue is
// busy, and it gets the expected data_out from the queue head. Accepted bytes
// are also collected from the DUT, and they are compared directly against the
// loaded bus.
// -----------------------------------------------------------------------------
module tb_result_serializer;

  localparam int NW    = 9;
  localparam int BPW   = 3;
  localparam int TB    = NW * BPW;
  localparam int BITS  = TB * 8;

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            reset;
  logic            load;
  logic            data_ready;
  logic [BITS-1:0] result_in;
  logic            ready;
  logic [7:0]      data_out;
  logic            data_valid;
  logic            done;

  always #5 clk = ~clk;

  result_serializer #(.NUM_WORDS(NW), .BYTES_PER_WORD(BPW)) dut (
    .clk        (clk),
    .reset      (reset),
    .result_in  (result_in),
    .load       (load),
    .ready      (ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .done       (done)
  );

  // ---------------- scoreboard state ----------------
  int          total = 0;
  int          bad   = 0;
  logic [7:0]  exp_q[$];      // bytes still owed by the active transfer
  logic [7:0]  rx_q[$];       // bytes actually accepted from the DUT
  bit          m_busy = 1'b0; // model: a transfer is in progress
  bit          m_done = 1'b0; // model: done expected this cycle
  int          done_cnt = 0;  // observed done pulses

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [BITS-1:0] rand_bus();
    logic [BITS-1:0] b;
    for (int k = 0; k < TB; k++) b[8*k +: 8] = 8'($urandom_range(255));
    return b;
  endfunction

  // ---------------- driver: one clock cycle ----------------
  // Inputs are applied 1 time unit after an edge. Outputs are checked
  // 1 time unit after the next edge.
  task automatic step(input bit rst, input bit ld, input bit rdy, input logic [BITS-1:0] bus);
    bit         stall_now;
    logic [7:0] out_now;
    reset      = rst;
    load       = ld;
    data_ready = rdy;
    result_in  = bus;
    stall_now  = data_valid && !rdy;
    out_now    = data_out;
    if (data_valid && rdy && !rst) rx_q.push_back(data_out);
    @(posedge clk);
    #1;
    // reference model
    m_done = 1'b0;
    if (rst) begin
      m_busy = 1'b0;
      exp_q.delete();
    end else if (m_busy) begin
      if (rdy) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
    end else if (ld) begin
      for (int k = 0; k < TB; k++) exp_q.push_back(bus[8*k +: 8]);
      m_busy = 1'b1;
    end
    if (done) done_cnt++;
    check_eq("ready",      ready,      !m_busy);
    check_eq("data_valid", data_valid, m_busy);
    check_eq("done",       done,       m_done);
    check_eq("data_out",   data_out,   m_busy ? exp_q[0] : 8'h00);
    if (stall_now && !rst) check_eq("hold", data_out, out_now);
  endtask

  // Load a bus, then clock until the model sees done or a cycle budget runs out.
  task automatic run_xfer(input logic [BITS-1:0] bus, input int stall_pct);
    int start_done;
    rx_q.delete();
    start_done = done_cnt;
    step(1'b0, 1'b1, 1'($urandom_range(1)), bus);
    for (int i = 0; i < 600; i++) begin
      step(1'b0, 1'b0, ($urandom_range(99) >= stall_pct), rand_bus());
      if (m_done) break;
    end
    check_eq("xfer_finished", m_done, 1'b1);
    check_eq("xfer_len",      rx_q.size(), TB);
    check_eq("xfer_done_cnt", done_cnt - start_done, 1);
    for (int k = 0; k < rx_q.size() && k < TB; k++)
      check_eq("xfer_byte", rx_q[k], bus[8*k +: 8]);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [BITS-1:0] bus_a;
    logic [BITS-1:0] bus_b;
    int              pct[4];
    pct[0] = 0; pct[1] = 30; pct[2] = 50; pct[3] = 80;

    reset = 1'b1; load = 1'b0; data_ready = 1'b0; result_in = '0;
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, rand_bus());
    check_eq("rst_ready", ready, 1'b1);
    check_eq("rst_valid", data_valid, 1'b0);
    check_eq("rst_data",  data_out, 8'h00);
    check_eq("rst_done",  done, 1'b0);
    step(1'b0, 1'b0, 1'b1, rand_bus());

    // Basic stream: byte k = k+1 with data_ready held high.
    for (int k = 0; k < TB; k++) bus_a[8*k +: 8] = 8'(k + 1);
    run_xfer(bus_a, 0);
    check_eq("basic_first", rx_q.size() > 0 ? rx_q[0] : 8'hxx, 8'h01);
    check_eq("basic_last",  rx_q.size() == TB ? rx_q[TB-1] : 8'hxx, 8'h1B);
    check_eq("basic_ready", ready, 1'b1);
    step(1'b0, 1'b0, 1'b1, rand_bus());

    // Backpressure with 50% stalls.
    run_xfer(rand_bus(), 50);
    step(1'b0, 1'b0, 1'b0, rand_bus());

    // Word order.
    bus_a = rand_bus();
    bus_a[0 +: 24]       = 24'hABCDEF;
    bus_a[8*24 +: 24]    = 24'h123456;
    run_xfer(bus_a, 20);
    if (rx_q.size() == TB) begin
      check_eq("wo_b0",  rx_q[0],  8'hEF);
      check_eq("wo_b1",  rx_q[1],  8'hCD);
      check_eq("wo_b2",  rx_q[2],  8'hAB);
      check_eq("wo_b24", rx_q[24], 8'h56);
      check_eq("wo_b25", rx_q[25], 8'h34);
      check_eq("wo_b26", rx_q[26], 8'h12);
    end
    step(1'b0, 1'b0, 1'b1, rand_bus());

    // Load during SEND at byte 10.
    bus_a = rand_bus();
    bus_b = ~bus_a;
    rx_q.delete();
    step(1'b0, 1'b1, 1'b1, bus_a);
    for (int i = 0; i < 100 && !m_done; i++)
      step(1'b0, (rx_q.size() == 10), 1'b1, (rx_q.size() == 10) ? bus_b : bus_a);
    check_eq("lds_len", rx_q.size(), TB);
    for (int k = 0; k < rx_q.size() && k < TB; k++)
      check_eq("lds_byte", rx_q[k], bus_a[8*k +: 8]);
    step(1'b0, 1'b0, 1'b1, rand_bus());

    // Reset mid-transfer after byte 5.
    rx_q.delete();
    step(1'b0, 1'b1, 1'b1, rand_bus());
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, rand_bus());
    check_eq("mid_rx5", rx_q.size(), 5);
    step(1'b1, 1'b0, 1'b1, rand_bus());
    check_eq("mid_valid", data_valid, 1'b0);
    check_eq("mid_data",  data_out, 8'h00);
    check_eq("mid_ready", ready, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, rand_bus());
    check_eq("mid_no_done", done_cnt, 4);
    run_xfer(rand_bus(), 0);

    // Back-to-back: load in the done cycle.
    check_eq("b2b_done_now", done, 1'b1);
    bus_a = rand_bus();
    step(1'b0, 1'b1, 1'b1, bus_a);
    check_eq("b2b_valid", data_valid, 1'b1);
    check_eq("b2b_first", data_out, bus_a[7:0]);
    for (int i = 0; i < 100 && !m_done; i++) step(1'b0, 1'b0, 1'b1, rand_bus());
    check_eq("b2b_end", m_done, 1'b1);

    // Randomized transfers, some back-to-back and some with idle gaps.
    for (int t = 0; t < 8; t++) begin
      run_xfer(rand_bus(), pct[$urandom_range(3)]);
      for (int g = 0; g < int'($urandom_range(2)); g++)
        step(1'b0, 1'b0, 1'($urandom_range(1)), rand_bus());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
